// File: rtl/dlatch_ar_rst_pkg.sv
// dlatch_ar_rst_pkg: shared default widths and reset value for dlatch_ar_rst
package dlatch_ar_rst_pkg;
  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 8;
  localparam logic [DEF_WIDTH-1:0] DEF_RST_VAL = '0;
endpackage

// File: rtl/dlatch_ar_rst_sat_counter.sv
// sat_counter: saturating counter; clk, rst (sync), clr (zero), inc (count up), cnt (value, holds at max)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/dlatch_ar_rst.sv
// dlatch_ar_rst: registered enable-hold; clk, rst (sync high), en (load), d -> q, q_vld (loaded since reset), upd (q changed pulse), hold_cnt (saturating cycles since load)
module dlatch_ar_rst
  import dlatch_ar_rst_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic             upd,
  output logic [CNT_W-1:0] hold_cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= RST_VAL;
      q_vld <= 1'b0;
      upd   <= 1'b0;
    end else begin
      q     <= en ? d : q;
      q_vld <= q_vld | en;
      upd   <= en && (d != q);
    end
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(en),
    .inc(!en),
    .cnt(hold_cnt)
  );
endmodule

// File: tb/tb_dlatch_ar_rst.sv
// tb_dlatch_ar_rst: directed self-checking bench for dlatch_ar_rst
module tb_dlatch_ar_rst;
  logic clk = 1'b0;
  logic rst, en, d;
  logic q, q_vld, upd;
  logic [7:0] hold_cnt;
  logic rst2, en2;
  logic [3:0] d2, q2;
  logic q_vld2, upd2;
  logic [1:0] hold_cnt2;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  dlatch_ar_rst u_dut (
    .clk(clk), .rst(rst), .en(en), .d(d),
    .q(q), .q_vld(q_vld), .upd(upd), .hold_cnt(hold_cnt)
  );
  dlatch_ar_rst #(.WIDTH(4), .RST_VAL(4'hA), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst2), .en(en2), .d(d2),
    .q(q2), .q_vld(q_vld2), .upd(upd2), .hold_cnt(hold_cnt2)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic chk1(input string tag, input logic [31:0] eq, input logic [31:0] ev, input logic [31:0] eu, input logic [31:0] ec);
    chk({tag, ".q"}, 32'(q), eq);
    chk({tag, ".q_vld"}, 32'(q_vld), ev);
    chk({tag, ".upd"}, 32'(upd), eu);
    chk({tag, ".hold_cnt"}, 32'(hold_cnt), ec);
  endtask
  task automatic chk2(input string tag, input logic [31:0] eq, input logic [31:0] ev, input logic [31:0] eu, input logic [31:0] ec);
    chk({tag, ".q2"}, 32'(q2), eq);
    chk({tag, ".q_vld2"}, 32'(q_vld2), ev);
    chk({tag, ".upd2"}, 32'(upd2), eu);
    chk({tag, ".hold_cnt2"}, 32'(hold_cnt2), ec);
  endtask
  initial begin
    rst = 1'b1; en = 1'bx; d = 1'bx;
    rst2 = 1'b1; en2 = 1'b0; d2 = 4'h0;
    @(negedge clk);
    tick();
    chk1("reset_x_inputs", 0, 0, 0, 0);
    rst = 1'b0; en = 1'b1; d = 1'b0;
    tick();
    chk1("first_load_0", 0, 1, 0, 0);
    d = 1'b1;
    tick();
    chk1("load_1", 1, 1, 1, 0);
    tick();
    chk1("load_equal", 1, 1, 0, 0);
    en = 1'b0; d = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("hold_cnt_step", 32'(hold_cnt), 32'(i));
      chk("hold_q", 32'(q), 1);
      chk("hold_upd", 32'(upd), 0);
    end
    chk1("hold_10", 1, 1, 0, 10);
    #3;
    chk("between_edges_q", 32'(q), 1);
    en = 1'b1; d = 1'b0;
    tick();
    chk1("load_after_hold", 0, 1, 1, 0);
    d = 1'b1;
    tick();
    chk1("track_1", 1, 1, 1, 0);
    en = 1'b0;
    tick();
    chk1("hold_1", 1, 1, 0, 1);
    rst = 1'b1;
    tick();
    chk1("rst_mid_hold", 0, 0, 0, 0);
    en = 1'b1; d = 1'b1;
    tick();
    chk1("rst_beats_en", 0, 0, 0, 0);
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      d = i[0];
      tick();
    end
    chk1("sat_255", 0, 0, 0, 255);
    en = 1'b1; d = 1'b1;
    tick();
    chk1("load_after_sat", 1, 1, 1, 0);
    rst = 1'b1;
    tick();
    chk1("rst_mid_load", 0, 0, 0, 0);
    tick();
    chk2("rst2", 32'hA, 0, 0, 0);
    rst2 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("sat2_cnt", 32'(hold_cnt2), (i < 3) ? 32'(i) : 3);
    end
    chk2("sat2_6", 32'hA, 0, 0, 3);
    en2 = 1'b1; d2 = 4'h5;
    tick();
    chk2("load2_5", 32'h5, 1, 1, 0);
    d2 = 4'hC;
    tick();
    chk2("load2_C", 32'hC, 1, 1, 0);
    rst2 = 1'b1; d2 = 4'h3;
    tick();
    chk2("rst2_wins", 32'hA, 0, 0, 0);
    rst2 = 1'b0; d2 = 4'hA;
    tick();
    chk2("load2_equal_rstval", 32'hA, 1, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
